// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit -- Coprocessor-0 exception/interrupt unit at the M stage.
//
// Decides whether the M-stage instruction traps, or whether a pending
// hardware interrupt is taken. Holds SR, Cause and EPC, and returns the
// constant PRId. Also serves mtc0/mfc0 and supplies EPC for eret.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   exc_code_in    ExcCode of the M-stage instruction (0 = none)
//   pc_in, bd_in   PC of that instruction and its delay-slot flag
//   hw_int         level-sensitive interrupt lines -> Cause.IP[15:10]
//   we/addr/din    mtc0 write port; addr also selects the mfc0 read
//   eret           eret in M stage (clears EXL)
//   dout           mfc0 read data (combinational)
//   epc_out        current EPC (combinational)
//   req            take exception/interrupt this cycle (combinational)
module cp0_exc_unit #(
  parameter logic [31:0] PRID = 32'h0000_2019
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  exc_code_in,
  input  logic [31:0] pc_in,
  input  logic        bd_in,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic        eret,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  // Only the implemented fields are stored; everything else reads as 0.
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:2] epc_q, epc_d;   // EPC[1:0] are hard zero

  logic        int_pend, exc_pend;
  logic [31:0] epc_tgt;
  logic [31:0] sr_rd, cause_rd, epc_rd;

  // EXL blocks both sources, so a handler is never re-entered.
  assign int_pend = (|(hw_int & im_q)) & ie_q & ~exl_q;
  assign exc_pend = (exc_code_in != 5'd0) & ~exl_q;
  assign req      = int_pend | exc_pend;

  // A delay-slot instruction restarts at its branch; wraps modulo 2^32.
  assign epc_tgt = bd_in ? (pc_in - 32'd4) : pc_in;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = hw_int;
    if (req) begin
      // Entry discards any same-cycle mtc0 or eret.
      exl_d = 1'b1;
      exc_d = int_pend ? 5'd0 : exc_code_in;
      bd_d  = bd_in;
      epc_d = epc_tgt[31:2];
    end else begin
      if (we && addr == A_SR) begin
        im_d  = din[15:10];
        exl_d = din[1];
        ie_d  = din[0];
      end
      if (we && addr == A_EPC)
        epc_d = din[31:2];
      // Placed after the SR write so eret wins on EXL.
      if (eret)
        exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  assign sr_rd    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_rd = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
  assign epc_rd   = {epc_q, 2'b00};
  assign epc_out  = epc_rd;

  always_comb begin
    case (addr)
      A_SR:    dout = sr_rd;
      A_CAUSE: dout = cause_rd;
      A_EPC:   dout = epc_rd;
      A_PRID:  dout = PRID;
      default: dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  exc_code_in;
  logic [31:0] pc_in;
  logic        bd_in;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic        eret;
  logic [31:0] dout;
  logic [31:0] epc_out;
  logic        req;

  cp0_exc_unit dut (
    .clk(clk), .reset(reset), .exc_code_in(exc_code_in), .pc_in(pc_in),
    .bd_in(bd_in), .hw_int(hw_int), .we(we), .addr(addr), .din(din),
    .eret(eret), .dout(dout), .epc_out(epc_out), .req(req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel: 0 = dout, 1 = req, 2 = epc_out
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: every expectation queued for this cycle is resolved on the
  // falling edge, with the cycle's inputs stable.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        0:       act = dout;
        1:       act = {31'd0, req};
        default: act = epc_out;
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; exc_code_in = '0; pc_in = '0; bd_in = 1'b0; hw_int = '0;
    we = 1'b0; addr = '0; din = '0; eret = 1'b0;
    step(); step();
    reset = 1'b0;

    // 1. arbitrary writes, then reset
    step(); we = 1'b1; addr = 5'd12; din = 32'h0000_FC03;
    step(); addr = 5'd14; din = 32'h1234_5678;
    step(); we = 1'b0; hw_int = 6'b111111; reset = 1'b1;
    step(); reset = 1'b0; hw_int = '0; addr = 5'd12;
    ex("rst_sr", 0, 32'h0); ex("rst_req", 1, 32'h0); ex("rst_epc", 2, 32'h0);
    step(); addr = 5'd13; ex("rst_cause", 0, 32'h0);
    step(); addr = 5'd14; ex("rst_epc_rd", 0, 32'h0);
    step(); addr = 5'd15; ex("prid", 0, 32'h0000_2019);

    // 2. exception entry
    step(); exc_code_in = 5'd10; pc_in = 32'h0000_3010; bd_in = 1'b0; addr = 5'd13;
    ex("exc_req", 1, 32'h1);
    step(); ex("exc_cause", 0, 32'h0000_0028); ex("exc_epc", 2, 32'h0000_3010);
    ex("exc_nonest", 1, 32'h0);
    step(); exc_code_in = 5'd0; addr = 5'd12; ex("exc_sr_exl", 0, 32'h0000_0002);

    // 3. delay-slot exception
    step(); eret = 1'b1; ex("eret_epc", 2, 32'h0000_3010); ex("eret_req", 1, 32'h0);
    step(); eret = 1'b0; ex("eret_exl", 0, 32'h0);
    step(); exc_code_in = 5'd4; pc_in = 32'h0000_3024; bd_in = 1'b1;
    ex("bd_req", 1, 32'h1);
    step(); exc_code_in = 5'd0; bd_in = 1'b0; addr = 5'd13;
    ex("bd_cause", 0, 32'h8000_0010); ex("bd_epc", 2, 32'h0000_3020);

    // 4. interrupt priority and masking
    step(); eret = 1'b1; addr = 5'd0;
    step(); eret = 1'b0; we = 1'b1; addr = 5'd12; din = 32'h0000_0401;
    ex("mtc0_sr_req", 1, 32'h0);
    step(); we = 1'b0; ex("sr_rd", 0, 32'h0000_0401);
    step(); hw_int = 6'b000001; exc_code_in = 5'd12; pc_in = 32'h0000_3100; addr = 5'd13;
    ex("int_req", 1, 32'h1);
    step(); hw_int = '0; exc_code_in = 5'd0;
    ex("int_cause", 0, 32'h0000_0400); ex("int_epc", 2, 32'h0000_3100);
    step(); addr = 5'd12; ex("int_sr", 0, 32'h0000_0403);
    step(); eret = 1'b1;
    step(); eret = 1'b0; hw_int = 6'b000010; exc_code_in = 5'd12; pc_in = 32'h0000_3200;
    ex("mask_req", 1, 32'h1);
    step(); hw_int = '0; exc_code_in = 5'd0; addr = 5'd13;
    ex("mask_cause", 0, 32'h0000_0830); ex("mask_epc", 2, 32'h0000_3200);

    // 5. eret and mtc0
    step(); eret = 1'b1; ex("eret2_epc", 2, 32'h0000_3200);
    step(); eret = 1'b0; addr = 5'd12; ex("eret2_sr", 0, 32'h0000_0401);
    step(); we = 1'b1; addr = 5'd14; din = 32'h0000_4003;
    step(); we = 1'b0; ex("mtc0_epc_rd", 0, 32'h0000_4000); ex("mtc0_epc_out", 2, 32'h0000_4000);
    step(); we = 1'b1; din = 32'h0000_5000; exc_code_in = 5'd8; pc_in = 32'h0000_3300;
    ex("drop_req", 1, 32'h1);
    step(); we = 1'b0; exc_code_in = 5'd0; ex("drop_epc", 0, 32'h0000_3300);
    step(); we = 1'b1; addr = 5'd12; din = 32'h0000_FC03; eret = 1'b1;
    step(); we = 1'b0; eret = 1'b0; ex("eret_wins", 0, 32'h0000_FC01);
    step(); exc_code_in = 5'd5; pc_in = 32'h0000_0000; bd_in = 1'b1;
    ex("wrap_req", 1, 32'h1);
    step(); exc_code_in = 5'd0; bd_in = 1'b0; addr = 5'd14;
    ex("wrap_epc", 0, 32'hFFFF_FFFC);
    step(); addr = 5'd3; ex("unmapped", 0, 32'h0);
    step(); we = 1'b1; addr = 5'd13; din = 32'hFFFF_FFFF;
    step(); we = 1'b0; ex("cause_ro", 0, 32'h8000_0014);

    // 6. reset mid-handler
    step(); hw_int = 6'b100000; reset = 1'b1;
    step(); reset = 1'b0; addr = 5'd13;
    ex("rst2_cause", 0, 32'h0); ex("rst2_req", 1, 32'h0); ex("rst2_epc", 2, 32'h0);
    step(); ex("rst2_ip", 0, 32'h0000_8000);
    step(); addr = 5'd12; ex("rst2_sr", 0, 32'h0); ex("rst2_req_b", 1, 32'h0);

    step(); step();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
